// File: rtl/ov7670_sccb_arbiter.sv
// Two-port arbiter in front of the OV7670 SCCB register-write sender.
// Port 0 (init) has strict priority; every write is followed by an idle gap, and a COM7 soft reset gets a longer one.
module ov7670_sccb_arbiter #(
   parameter int unsigned GAP_CYCLES        = 2500,
   parameter int unsigned RESET_WAIT_CYCLES = 25000,
   parameter int unsigned TIMEOUT_CYCLES    = 50000,
   parameter int unsigned CNT_W             = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   output logic        send,
   output logic [7:0]  reg_addr,
   output logic [7:0]  value,
   input  logic        taken,
   output logic        busy,
   output logic        grant_id,
   output logic        timeout,
   output logic [15:0] xfer_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

   localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] ResetLoad = CNT_W'(RESET_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] SendLast  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       val_q, val_d;
   logic             grant_q, grant_d;
   logic             timeout_q, timeout_d;
   logic [15:0]      count_q, count_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] gcnt_q, gcnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         val_q     <= '0;
         grant_q   <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= '0;
         tcnt_q    <= '0;
         gcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         val_q     <= val_d;
         grant_q   <= grant_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         tcnt_q    <= tcnt_d;
         gcnt_q    <= gcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      val_d     = val_q;
      grant_d   = grant_q;
      timeout_d = 1'b0;
      count_d   = count_q;
      tcnt_d    = tcnt_q;
      gcnt_d    = gcnt_q;
      case (state_q)
         IDLE: begin
            if (req0_valid) begin
               addr_d  = req0_data[15:8];
               val_d   = req0_data[7:0];
               grant_d = 1'b0;
               tcnt_d  = '0;
               state_d = SEND;
            end else if (req1_valid) begin
               addr_d  = req1_data[15:8];
               val_d   = req1_data[7:0];
               grant_d = 1'b1;
               tcnt_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // A taken arriving on the final allowed cycle still wins over the timeout.
            if (taken) begin
               count_d = count_q + 16'd1;
               gcnt_d  = (addr_q == 8'h12 && val_q[7]) ? ResetLoad : GapLoad;
               state_d = GAP;
            end else if (tcnt_q == SendLast) begin
               timeout_d = 1'b1;
               gcnt_d    = GapLoad;
               state_d   = GAP;
            end else begin
               tcnt_d = tcnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            gcnt_d = (gcnt_q == '0) ? '0 : gcnt_q - CNT_W'(1);
            if (gcnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = (state_q == IDLE);
      req1_ready = (state_q == IDLE) & ~req0_valid;
      send       = (state_q == SEND);
      busy       = (state_q != IDLE);
      reg_addr   = addr_q;
      value      = val_q;
      grant_id   = grant_q;
      timeout    = timeout_q;
      xfer_count = count_q;
   end

endmodule

// File: doc/ov7670_sccb_arbiter.md
Name: ov7670_sccb_arbiter

Overview:
- Shares the single SCCB register-write sender between two requesters:
  - port 0: the power-up register init sequence.
  - port 1: runtime register updates such as exposure, gain and test pattern.
- Enforces a mandatory idle gap between consecutive writes.
- Enforces a long settle wait after a COM7 soft-reset write.
- Recovers from a sender that never accepts a word (timeout).
- Sits between the requesters and the SCCB sender, driving its send/reg_addr/value inputs and consuming its taken pulse.

Parameters:
GAP_CYCLES, 2500, idle cycles after every completed write (>=1).
RESET_WAIT_CYCLES, 25000, idle cycles after a COM7 soft-reset write (>=1).
TIMEOUT_CYCLES, 50000, max cycles in SEND waiting for taken before abort (>=2).
CNT_W, 16, width of gap/timeout counters; must hold max(GAP_CYCLES, RESET_WAIT_CYCLES, TIMEOUT_CYCLES).

Ports:
clk  input  1  core clock
reset_n  input  1  reset; asynchronous, active-low
req0_valid  input  1  port 0 (init) has a word
req0_data  input  16  port 0 word: [15:8] register address, [7:0] value
req0_ready  output  1  port 0 word accepted this cycle when valid&ready
req1_valid  input  1  port 1 (runtime) has a word
req1_data  input  16  port 1 word, same format
req1_ready  output  1  port 1 accept
send  output  1  request to sender, held until taken
reg_addr  output  8  register address to sender
value  output  8  register value to sender
taken  input  1  one-cycle pulse: sender has latched reg_addr/value
busy  output  1  state != IDLE
grant_id  output  1  port that owns the current/last transfer
timeout  output  1  one-cycle pulse on SEND abort
xfer_count  output  16  number of words completed via taken, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): state=IDLE, send=0, reg_addr=0, value=0, grant_id=0, timeout=0, xfer_count=0, counters=0.
- States: IDLE, SEND, GAP.
- Ready logic (combinational):
  - req0_ready = (state==IDLE).
  - req1_ready = (state==IDLE) & ~req0_valid.
  - Port 0 has strict priority, so simultaneous valids grant port 0.
  - Ready never depends on the port's own valid.
- IDLE:
  - A handshake on port N latches reqN_data into reg_addr/value and sets grant_id=N.
  - Next cycle: state=SEND, send=1, timeout counter cleared.
  - With no valid, the block stays in IDLE.
- SEND:
  - send=1; reg_addr/value held stable.
  - Timeout counter increments each cycle.
  - taken=1 while in SEND:
    - next cycle send=0, xfer_count+1, state=GAP.
    - Gap counter loaded with RESET_WAIT_CYCLES if reg_addr==8'h12 and value[7]==1, else GAP_CYCLES.
  - No taken for TIMEOUT_CYCLES cycles in SEND:
    - next cycle send=0, timeout=1 for one cycle, xfer_count unchanged.
    - Gap counter loaded with GAP_CYCLES; state=GAP.
  - taken on the same cycle the timeout expires counts as success.
  - taken outside SEND is ignored.
- GAP:
  - send=0; gap counter decrements.
  - GAP lasts exactly the loaded number of cycles, then state=IDLE.
  - The earliest next handshake is the first IDLE cycle.
- Handshake to send latency: 1 cycle.
- taken to send low: 1 cycle.
- reg_addr/value/grant_id hold their last values outside SEND.
- Reset asserted mid-SEND or mid-GAP aborts immediately to reset values; the in-flight word is lost (no retry).
- No queuing: a requester must hold valid and data until the handshake.

Test Plan:
- Port 0 word 16'h1280 (COM7 reset), taken 5 cycles after send:
  - send high the cycle after handshake, reg_addr=12, value=80.
  - send low the cycle after taken; busy stays high for RESET_WAIT_CYCLES; xfer_count=1.
- Port 0 word 16'h1100, taken after 3 cycles:
  - GAP lasts exactly GAP_CYCLES; req0_ready returns high on the following cycle.
- Both valid same cycle (port 0 16'h3A04, port 1 16'h0010):
  - port 0 served first with grant_id=0.
  - port 1 served after the gap with grant_id=1.
  - req1_ready stays low while req0_valid is high.
- Port 1 word, taken never pulses:
  - send held for TIMEOUT_CYCLES; then timeout=1 for exactly one cycle, send=0.
  - xfer_count unchanged; IDLE after GAP_CYCLES.
- reset_n pulsed low mid-SEND:
  - all outputs at reset values asynchronously; after release, a new port 1 word completes normally.
- Stray taken pulse while in IDLE/GAP:
  - no state or xfer_count change.
